// File: rtl/cpu_bus_pkg.sv
// Shared types and helpers for the CPU-side memory arbiter: bus source IDs,
// grant FSM states, dBus access sizes and the size/address-to-byte-enable map.
package cpu_bus_pkg;

  typedef enum logic {
    SRC_IBUS = 1'b0,
    SRC_DBUS = 1'b1
  } src_e;

  typedef enum logic [1:0] {
    GS_IDLE   = 2'd0,
    GS_HOLD_I = 2'd1,
    GS_HOLD_D = 2'd2
  } grant_state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Size 3 is not a legal access; it yields no enabled lanes.
  function automatic logic [3:0] size_to_be(input logic [1:0] size, input logic [1:0] addr_lsb);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lsb;
      SZ_HALF: be = addr_lsb[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/cpu_mem_src_fifo.sv
// One-bit-wide synchronous FIFO remembering which bus issued each outstanding
// read, so in-order memory responses can be steered back to their requester.
module cpu_mem_src_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Overflow and underflow requests are ignored rather than corrupting state.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Round-robin arbiter sharing one in-order memory port between the CPU iBus
// and dBus, with byte-enable generation and read-response routing.
module cpu_mem_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_cpu,
  input  logic              clk_cpu_reset_,
  input  logic              iBus_cmd_valid,
  output logic              iBus_cmd_ready,
  input  logic [ADDR_W-1:0] iBus_cmd_payload_pc,
  output logic              iBus_rsp_valid,
  output logic              iBus_rsp_payload_error,
  output logic [31:0]       iBus_rsp_payload_inst,
  input  logic              dBus_cmd_valid,
  output logic              dBus_cmd_ready,
  input  logic              dBus_cmd_payload_wr,
  input  logic [ADDR_W-1:0] dBus_cmd_payload_address,
  input  logic [31:0]       dBus_cmd_payload_data,
  input  logic [1:0]        dBus_cmd_payload_size,
  output logic              dBus_rsp_ready,
  output logic              dBus_rsp_error,
  output logic [31:0]       dBus_rsp_data,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_wr,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [3:0]        mem_cmd_be,
  output logic [31:0]       mem_cmd_wdata,
  input  logic              mem_rsp_valid,
  input  logic              mem_rsp_error,
  input  logic [31:0]       mem_rsp_data,
  output logic              err_orphan_rsp,
  output logic              err_bad_size
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  grant_state_e state_q, state_d;
  src_e         last_grant_q, last_grant_d, sel_src;
  logic         err_orphan_q, err_orphan_d, err_size_q, err_size_d;
  logic         sel_valid, sel_is_read, accept;
  logic         fifo_full, fifo_empty, fifo_head, fifo_push, fifo_pop;
  logic         rsp_to_ibus, rsp_to_dbus;

  // In IDLE the choice is round-robin; once held, the selection is frozen.
  always_comb begin
    sel_src = SRC_DBUS;
    case (state_q)
      GS_IDLE:   sel_src = (iBus_cmd_valid && (!dBus_cmd_valid || last_grant_q == SRC_DBUS))
                           ? SRC_IBUS : SRC_DBUS;
      GS_HOLD_I: sel_src = SRC_IBUS;
      default:   sel_src = SRC_DBUS;
    endcase
  end

  assign sel_valid      = (sel_src == SRC_IBUS) ? iBus_cmd_valid : dBus_cmd_valid;
  assign sel_is_read    = (sel_src == SRC_IBUS) || !dBus_cmd_payload_wr;
  assign mem_cmd_valid  = sel_valid && !(sel_is_read && fifo_full);
  assign accept         = mem_cmd_valid && mem_cmd_ready;
  assign iBus_cmd_ready = accept && (sel_src == SRC_IBUS);
  assign dBus_cmd_ready = accept && (sel_src == SRC_DBUS);

  always_comb begin
    mem_cmd_wr    = 1'b0;
    mem_cmd_addr  = '0;
    mem_cmd_be    = 4'b0000;
    mem_cmd_wdata = '0;
    if (mem_cmd_valid) begin
      if (sel_src == SRC_IBUS) begin
        mem_cmd_addr = iBus_cmd_payload_pc & WORD_MASK;
        mem_cmd_be   = 4'b1111;
      end else begin
        mem_cmd_wr    = dBus_cmd_payload_wr;
        mem_cmd_addr  = dBus_cmd_payload_address & WORD_MASK;
        mem_cmd_be    = size_to_be(dBus_cmd_payload_size, dBus_cmd_payload_address[1:0]);
        mem_cmd_wdata = dBus_cmd_payload_data;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    err_size_d   = err_size_q;
    err_orphan_d = err_orphan_q;
    case (state_q)
      GS_IDLE: begin
        if (mem_cmd_valid && !mem_cmd_ready) begin
          state_d = (sel_src == SRC_IBUS) ? GS_HOLD_I : GS_HOLD_D;
        end
      end
      GS_HOLD_I, GS_HOLD_D: begin
        if (accept) state_d = GS_IDLE;
      end
      default: state_d = GS_IDLE;
    endcase
    if (accept) last_grant_d = sel_src;
    if (dBus_cmd_ready && dBus_cmd_payload_size == 2'd3) err_size_d = 1'b1;
    if (mem_rsp_valid && fifo_empty) err_orphan_d = 1'b1;
  end

  always_ff @(posedge clk_cpu or negedge clk_cpu_reset_) begin
    if (!clk_cpu_reset_) begin
      state_q      <= GS_IDLE;
      last_grant_q <= SRC_DBUS;
      err_size_q   <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      err_size_q   <= err_size_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  // Only reads expect a response, so only reads record their source.
  assign fifo_push = accept && sel_is_read;
  assign fifo_pop  = mem_rsp_valid && !fifo_empty;

  cpu_mem_src_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_src_fifo (
    .clk_i  (clk_cpu),
    .rst_ni (clk_cpu_reset_),
    .push_i (fifo_push),
    .din_i  (sel_src == SRC_DBUS),
    .pop_i  (fifo_pop),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .head_o (fifo_head)
  );

  assign rsp_to_ibus = fifo_pop && !fifo_head;
  assign rsp_to_dbus = fifo_pop && fifo_head;

  assign iBus_rsp_valid         = rsp_to_ibus;
  assign iBus_rsp_payload_error = rsp_to_ibus && mem_rsp_error;
  assign iBus_rsp_payload_inst  = rsp_to_ibus ? mem_rsp_data : '0;
  assign dBus_rsp_ready         = rsp_to_dbus;
  assign dBus_rsp_error         = rsp_to_dbus && mem_rsp_error;
  assign dBus_rsp_data          = rsp_to_dbus ? mem_rsp_data : '0;

  assign err_orphan_rsp = err_orphan_q;
  assign err_bad_size   = err_size_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: per-cycle vectors with hand-computed
// expectations, plus hand-written reset sequences.
module tb_cpu_mem_arbiter;

  logic        clk_cpu = 1'b0;
  logic        clk_cpu_reset_ = 1'b0;
  logic        iBus_cmd_valid, iBus_cmd_ready;
  logic [31:0] iBus_cmd_payload_pc;
  logic        iBus_rsp_valid, iBus_rsp_payload_error;
  logic [31:0] iBus_rsp_payload_inst;
  logic        dBus_cmd_valid, dBus_cmd_ready, dBus_cmd_payload_wr;
  logic [31:0] dBus_cmd_payload_address, dBus_cmd_payload_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        dBus_rsp_ready, dBus_rsp_error;
  logic [31:0] dBus_rsp_data;
  logic        mem_cmd_valid, mem_cmd_ready, mem_cmd_wr;
  logic [31:0] mem_cmd_addr, mem_cmd_wdata;
  logic [3:0]  mem_cmd_be;
  logic        mem_rsp_valid, mem_rsp_error;
  logic [31:0] mem_rsp_data;
  logic        err_orphan_rsp, err_bad_size;

  int total = 0;
  int bad   = 0;

  always #5 clk_cpu = ~clk_cpu;

  cpu_mem_arbiter #(
    .MAX_OUTST(4),
    .ADDR_W   (32)
  ) dut (
    .clk_cpu                 (clk_cpu),
    .clk_cpu_reset_          (clk_cpu_reset_),
    .iBus_cmd_valid          (iBus_cmd_valid),
    .iBus_cmd_ready          (iBus_cmd_ready),
    .iBus_cmd_payload_pc     (iBus_cmd_payload_pc),
    .iBus_rsp_valid          (iBus_rsp_valid),
    .iBus_rsp_payload_error  (iBus_rsp_payload_error),
    .iBus_rsp_payload_inst   (iBus_rsp_payload_inst),
    .dBus_cmd_valid          (dBus_cmd_valid),
    .dBus_cmd_ready          (dBus_cmd_ready),
    .dBus_cmd_payload_wr     (dBus_cmd_payload_wr),
    .dBus_cmd_payload_address(dBus_cmd_payload_address),
    .dBus_cmd_payload_data   (dBus_cmd_payload_data),
    .dBus_cmd_payload_size   (dBus_cmd_payload_size),
    .dBus_rsp_ready          (dBus_rsp_ready),
    .dBus_rsp_error          (dBus_rsp_error),
    .dBus_rsp_data           (dBus_rsp_data),
    .mem_cmd_valid           (mem_cmd_valid),
    .mem_cmd_ready           (mem_cmd_ready),
    .mem_cmd_wr              (mem_cmd_wr),
    .mem_cmd_addr            (mem_cmd_addr),
    .mem_cmd_be              (mem_cmd_be),
    .mem_cmd_wdata           (mem_cmd_wdata),
    .mem_rsp_valid           (mem_rsp_valid),
    .mem_rsp_error           (mem_rsp_error),
    .mem_rsp_data            (mem_rsp_data),
    .err_orphan_rsp          (err_orphan_rsp),
    .err_bad_size            (err_bad_size)
  );

  // eRdy = {iBus_cmd_ready, dBus_cmd_ready}; eRsp = {iRspValid, iRspErr, dRspValid, dRspErr};
  // eErr = {err_orphan_rsp, err_bad_size}
  typedef struct {
    string       name;
    logic        iv;
    logic [31:0] pc;
    logic        dv;
    logic        dwr;
    logic [31:0] da;
    logic [31:0] dd;
    logic [1:0]  dsz;
    logic        mrdy;
    logic        rv;
    logic        re;
    logic [31:0] rd;
    logic [1:0]  eRdy;
    logic        eMv;
    logic        eMwr;
    logic [31:0] eAddr;
    logic [3:0]  eBe;
    logic [31:0] eWd;
    logic [3:0]  eRsp;
    logic [31:0] eRdata;
    logic [1:0]  eErr;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(string name, logic iv, logic [31:0] pc, logic dv, logic dwr,
                        logic [31:0] da, logic [31:0] dd, logic [1:0] dsz, logic mrdy,
                        logic rv, logic re, logic [31:0] rd, logic [1:0] eRdy, logic eMv,
                        logic eMwr, logic [31:0] eAddr, logic [3:0] eBe, logic [31:0] eWd,
                        logic [3:0] eRsp, logic [31:0] eRdata, logic [1:0] eErr);
    vec_t v;
    v.name = name; v.iv = iv; v.pc = pc; v.dv = dv; v.dwr = dwr; v.da = da; v.dd = dd;
    v.dsz = dsz; v.mrdy = mrdy; v.rv = rv; v.re = re; v.rd = rd; v.eRdy = eRdy;
    v.eMv = eMv; v.eMwr = eMwr; v.eAddr = eAddr; v.eBe = eBe; v.eWd = eWd;
    v.eRsp = eRsp; v.eRdata = eRdata; v.eErr = eErr;
    vecs.push_back(v);
  endtask

  task automatic compareField(string what, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h want=%h", what, act, exp);
    end
  endtask

  task automatic idleInputs();
    iBus_cmd_valid = 0; iBus_cmd_payload_pc = 0;
    dBus_cmd_valid = 0; dBus_cmd_payload_wr = 0; dBus_cmd_payload_address = 0;
    dBus_cmd_payload_data = 0; dBus_cmd_payload_size = 0;
    mem_cmd_ready = 0; mem_rsp_valid = 0; mem_rsp_error = 0; mem_rsp_data = 0;
  endtask

  task automatic checkAllZero(string tag);
    compareField({tag, ".iRdy"}, iBus_cmd_ready, 0);
    compareField({tag, ".dRdy"}, dBus_cmd_ready, 0);
    compareField({tag, ".mValid"}, mem_cmd_valid, 0);
    compareField({tag, ".mWr"}, mem_cmd_wr, 0);
    compareField({tag, ".mAddr"}, mem_cmd_addr, 0);
    compareField({tag, ".mBe"}, mem_cmd_be, 0);
    compareField({tag, ".mWdata"}, mem_cmd_wdata, 0);
    compareField({tag, ".iRspV"}, iBus_rsp_valid, 0);
    compareField({tag, ".iRspErr"}, iBus_rsp_payload_error, 0);
    compareField({tag, ".iInst"}, iBus_rsp_payload_inst, 0);
    compareField({tag, ".dRspV"}, dBus_rsp_ready, 0);
    compareField({tag, ".dRspErr"}, dBus_rsp_error, 0);
    compareField({tag, ".dData"}, dBus_rsp_data, 0);
    compareField({tag, ".errOrphan"}, err_orphan_rsp, 0);
    compareField({tag, ".errSize"}, err_bad_size, 0);
  endtask

  task automatic resetDut(string tag);
    @(negedge clk_cpu);
    idleInputs();
    clk_cpu_reset_ = 0;
    #2;
    checkAllZero(tag);
    @(negedge clk_cpu);
    clk_cpu_reset_ = 1;
  endtask

  task automatic applyStimulus(vec_t v);
    @(negedge clk_cpu);
    iBus_cmd_valid = v.iv; iBus_cmd_payload_pc = v.pc;
    dBus_cmd_valid = v.dv; dBus_cmd_payload_wr = v.dwr; dBus_cmd_payload_address = v.da;
    dBus_cmd_payload_data = v.dd; dBus_cmd_payload_size = v.dsz;
    mem_cmd_ready = v.mrdy; mem_rsp_valid = v.rv; mem_rsp_error = v.re; mem_rsp_data = v.rd;
    #1;
  endtask

  task automatic checkOutput(vec_t v);
    compareField({v.name, ".iRdy"}, iBus_cmd_ready, v.eRdy[1]);
    compareField({v.name, ".dRdy"}, dBus_cmd_ready, v.eRdy[0]);
    compareField({v.name, ".mValid"}, mem_cmd_valid, v.eMv);
    if (v.eMv) begin
      compareField({v.name, ".mWr"}, mem_cmd_wr, v.eMwr);
      compareField({v.name, ".mAddr"}, mem_cmd_addr, v.eAddr);
      compareField({v.name, ".mBe"}, mem_cmd_be, v.eBe);
      compareField({v.name, ".mWdata"}, mem_cmd_wdata, v.eWd);
    end
    compareField({v.name, ".iRspV"}, iBus_rsp_valid, v.eRsp[3]);
    compareField({v.name, ".iRspErr"}, iBus_rsp_payload_error, v.eRsp[2]);
    compareField({v.name, ".dRspV"}, dBus_rsp_ready, v.eRsp[1]);
    compareField({v.name, ".dRspErr"}, dBus_rsp_error, v.eRsp[0]);
    if (v.eRsp[3]) compareField({v.name, ".iInst"}, iBus_rsp_payload_inst, v.eRdata);
    if (v.eRsp[1]) compareField({v.name, ".dData"}, dBus_rsp_data, v.eRdata);
    compareField({v.name, ".errOrphan"}, err_orphan_rsp, v.eErr[1]);
    compareField({v.name, ".errSize"}, err_bad_size, v.eErr[0]);
  endtask

  task automatic runVecs();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i]);
    end
    vecs.delete();
    @(negedge clk_cpu);
    idleInputs();
  endtask

  initial begin
    idleInputs();
    resetDut("reset0");

    // Lone fetch, response two cycles later.
    addVec("t1_fetch", 1, 'h100, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 'h100, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t1_wait",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 2'b00);
    addVec("t1_rsp",   0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'hDEADBEEF, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 'hDEADBEEF, 2'b00);
    runVecs();

    // Both buses requesting every cycle: I, D, I, D with in-order routing.
    resetDut("reset2");
    addVec("t2_g1_i", 1, 'h200, 1, 0, 'h300, 0, 2, 1, 0, 0, 0, 2'b10, 1, 0, 'h200, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t2_g2_d", 1, 'h200, 1, 0, 'h300, 0, 2, 1, 1, 0, 'h11111111, 2'b01, 1, 0, 'h300, 4'hF, 0, 4'b1000, 'h11111111, 2'b00);
    addVec("t2_g3_i", 1, 'h200, 1, 0, 'h300, 0, 2, 1, 1, 0, 'h22222222, 2'b10, 1, 0, 'h200, 4'hF, 0, 4'b0010, 'h22222222, 2'b00);
    addVec("t2_g4_d", 1, 'h200, 1, 0, 'h300, 0, 2, 1, 1, 1, 'h33333333, 2'b01, 1, 0, 'h300, 4'hF, 0, 4'b1100, 'h33333333, 2'b00);
    addVec("t2_drain", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h44444444, 2'b00, 0, 0, 0, 0, 0, 4'b0010, 'h44444444, 2'b00);
    runVecs();

    // dBus store stalled three cycles while iBus rises; then iBus wins.
    resetDut("reset3");
    addVec("t3_stall1", 0, 0, 1, 1, 'h402, 'h12345678, 1, 0, 0, 0, 0, 2'b00, 1, 1, 'h400, 4'hC, 'h12345678, 4'b0000, 0, 2'b00);
    addVec("t3_stall2", 1, 'h500, 1, 1, 'h402, 'h12345678, 1, 0, 0, 0, 0, 2'b00, 1, 1, 'h400, 4'hC, 'h12345678, 4'b0000, 0, 2'b00);
    addVec("t3_stall3", 1, 'h500, 1, 1, 'h402, 'h12345678, 1, 0, 0, 0, 0, 2'b00, 1, 1, 'h400, 4'hC, 'h12345678, 4'b0000, 0, 2'b00);
    addVec("t3_acc_d",  1, 'h500, 1, 1, 'h402, 'h12345678, 1, 1, 0, 0, 0, 2'b01, 1, 1, 'h400, 4'hC, 'h12345678, 4'b0000, 0, 2'b00);
    addVec("t3_then_i", 1, 'h500, 1, 1, 'h404, 0, 2, 1, 0, 0, 0, 2'b10, 1, 0, 'h500, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t3_rsp",    0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h55555555, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 'h55555555, 2'b00);
    runVecs();

    // FIFO fills; a store still passes; reads wait until a slot frees on a later cycle.
    resetDut("reset4");
    addVec("t4_rd0", 1, 'h600, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 'h600, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t4_rd1", 1, 'h604, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 'h604, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t4_rd2", 1, 'h608, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 'h608, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t4_rd3", 1, 'h60C, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 'h60C, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t4_full_store", 1, 'h610, 1, 1, 'h203, 'hAB000000, 0, 1, 0, 0, 0, 2'b01, 1, 1, 'h200, 4'b1000, 'hAB000000, 4'b0000, 0, 2'b00);
    addVec("t4_blocked", 1, 'h610, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 2'b00);
    addVec("t5_rsp_full", 1, 'h610, 0, 0, 0, 0, 0, 1, 1, 0, 'h66666666, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 'h66666666, 2'b00);
    addVec("t5_read_next", 1, 'h610, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 1, 0, 'h610, 4'hF, 0, 4'b0000, 0, 2'b00);
    addVec("t5_drain0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h70000000, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 'h70000000, 2'b00);
    addVec("t5_drain1", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h70000001, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 'h70000001, 2'b00);
    addVec("t5_drain2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h70000002, 2'b00, 0, 0, 0, 0, 0, 4'b1000, 'h70000002, 2'b00);
    addVec("t5_drain3", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h70000003, 2'b00, 0, 0, 0, 0, 0, 4'b1100, 'h70000003, 2'b00);
    // Orphan response and an illegal size; both flags are sticky.
    addVec("t6_orphan", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h99999999, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 2'b00);
    addVec("t6_bad_size", 0, 0, 1, 1, 'h700, 'h00000001, 3, 1, 0, 0, 0, 2'b01, 1, 1, 'h700, 4'h0, 'h1, 4'b0000, 0, 2'b10);
    addVec("t6_sticky1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 2'b11);
    addVec("t6_sticky2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 4'b0000, 0, 2'b11);
    runVecs();
    resetDut("reset6_flags_clear");

    // Byte-enable lanes for the remaining sizes and offsets, plus a sub-word load.
    addVec("t7_b1", 0, 0, 1, 1, 'h801, 'h0000CD00, 0, 1, 0, 0, 0, 2'b01, 1, 1, 'h800, 4'b0010, 'h0000CD00, 4'b0000, 0, 2'b00);
    addVec("t7_b2", 0, 0, 1, 1, 'h802, 'h00EF0000, 0, 1, 0, 0, 0, 2'b01, 1, 1, 'h800, 4'b0100, 'h00EF0000, 4'b0000, 0, 2'b00);
    addVec("t7_h0", 0, 0, 1, 1, 'h800, 'h00001234, 1, 1, 0, 0, 0, 2'b01, 1, 1, 'h800, 4'b0011, 'h00001234, 4'b0000, 0, 2'b00);
    addVec("t7_w",  0, 0, 1, 1, 'h806, 'hCAFEF00D, 2, 1, 0, 0, 0, 2'b01, 1, 1, 'h804, 4'b1111, 'hCAFEF00D, 4'b0000, 0, 2'b00);
    addVec("t7_ld", 0, 0, 1, 0, 'h803, 0, 0, 1, 0, 0, 0, 2'b01, 1, 0, 'h800, 4'b1000, 0, 4'b0000, 0, 2'b00);
    addVec("t7_ld_rsp", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 'h5A000000, 2'b00, 0, 0, 0, 0, 0, 4'b0011, 'h5A000000, 2'b00);
    runVecs();

    // Reset in the middle of an outstanding read: its response becomes an orphan.
    @(negedge clk_cpu);
    iBus_cmd_valid = 1; iBus_cmd_payload_pc = 'h900; mem_cmd_ready = 1;
    #1;
    compareField("mid_rst.issue_iRdy", iBus_cmd_ready, 1);
    @(negedge clk_cpu);
    idleInputs();
    #2;
    clk_cpu_reset_ = 0;
    #1;
    checkAllZero("mid_rst.during");
    @(negedge clk_cpu);
    clk_cpu_reset_ = 1;
    @(negedge clk_cpu);
    mem_rsp_valid = 1; mem_rsp_data = 'hBAD0BAD0;
    #1;
    compareField("mid_rst.iRspV", iBus_rsp_valid, 0);
    compareField("mid_rst.dRspV", dBus_rsp_ready, 0);
    @(negedge clk_cpu);
    idleInputs();
    #1;
    compareField("mid_rst.errOrphan", err_orphan_rsp, 1);
    compareField("mid_rst.errSize", err_bad_size, 0);
    resetDut("final_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
